multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control unit for the MIPS datapath. It is the sequential successor to the single-cycle opcode decoder. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives the shared-memory and register-file enables, with a ready/request handshake to memory. It adds a memory-wait timeout, illegal-opcode trapping, correct ALU ops for ANDI/ORI, and an optional jump.

## Interface
- OPCODE_W, 6: opcode field width
- ALUOP_W, 3: ALU op width (min 3)
- MEM_TIMEOUT, 16: max cycles waiting on mem_ready; 0 disables the timeout
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  OPCODE_W  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_read / mem_write  out  1  access direction
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write, pc_write, pc_write_cond, pc_write_ne  out  1  IR/PC enables
- reg_dst, reg_write, mem_to_reg  out  1  register-file controls
- alu_src_a  out  1 ; alu_src_b  out  2 ; alu_op  out  ALUOP_W ; pc_source  out  2
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction
- illegal_op, bus_err  out  1  sticky trap flags

## Operation
- alu_op encodings: 000 add, 001 sub, 010 R-type (funct), 011 and, 100 or.
- alu_src_b encodings: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- pc_source encodings: 00 ALU, 01 ALUOut, 10 jump target.
- Outputs are decoded from the state register (Moore). The only exception: in FETCH, ir_write and pc_write are also gated by mem_ready.
- FETCH: mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00. Go to DECODE on mem_ready.
- DECODE: alu_src_b=11, alu_op=000 (branch target). Dispatch on opcode:
  - 0 → EXEC_R
  - 35/43 → MEM_ADDR
  - 4/5 → BRANCH
  - 8/12/13 → EXEC_I
  - 2 → JUMP (macro-gated)
  - any other opcode → TRAP with illegal_op=1
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010. Next R_WB: reg_dst=1, reg_write=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op 000/011/100 for ADDI/ANDI/ORI. Next I_WB: reg_dst=0, reg_write=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000.
  - LW → MEM_READ (mem_req, mem_read, iord=1) → MEM_WB (mem_to_reg=1, reg_write=1).
  - SW → MEM_WRITE (mem_req, mem_write, iord=1) → FETCH.
- The opcode is latched in DECODE, so the LW/SW choice and the EXEC_I alu_op use the latched copy.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01. Asserts pc_write_cond for BEQ or pc_write_ne for BNE.
- JUMP: pc_write=1, pc_source=10.
- Memory states hold mem_req and their controls unchanged until mem_ready=1, then advance.
- The wait counter clears on entering any memory state and increments each cycle with mem_req=1 and mem_ready=0.
- Timeout: when the counter reaches MEM_TIMEOUT with mem_ready still 0 → TRAP with bus_err=1. If mem_ready=1 in that same cycle, mem_ready wins.
- TRAP: all enables and mem_req are 0; the FSM stays in TRAP until reset.
- instr_done is asserted in R_WB, I_WB, MEM_WB, BRANCH and JUMP, and in MEM_WRITE on the mem_ready cycle.

## Timing
- Reset, rst_n=0 at a rising edge:
  - state goes to FETCH; wait counter, latched opcode, illegal_op and bus_err clear.
  - Outputs then equal FETCH decode: mem_req=1, mem_read=1, alu_src_b=01, all others 0.
- Reset mid-instruction or mid-access abandons the operation; no write enable is asserted in the cycle after reset.
- Minimum cycles per instruction, assuming mem_ready=1 immediately:
  - LW 5; R-type, SW, ADDI/ANDI/ORI 4; BEQ/BNE, J 3.
- Every cycle with mem_ready=0 in a memory state adds one cycle.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN defined: opcode 2 goes to JUMP, which updates the PC in one cycle.
- Macro undefined: the JUMP state and pc_source=10 are absent; opcode 2 traps with illegal_op=1.

## Structure
- ctrl_pkg holds:
  - opcode constants (R_FORMAT, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, J)
  - the state enum
  - alu_op, alu_src_b and pc_source encodings
- One sub-module, opcode_class: a combinational map from opcode to class (R, MEM, BR, IMM, JMP, ILLEGAL) plus the per-opcode alu_op.

## Test plan
- After reset, run an ADD then a LW with mem_ready tied 1 → FETCH lasts 1 cycle. instr_done pulses at cycle 4 for ADD, then at cycle 9 for LW. reg_write is asserted in R_WB and again in MEM_WB.
- ORI (13) → EXEC_I drives alu_op=100 and alu_src_b=10. ANDI (12) → alu_op=011.
- SW with mem_ready low for 3 cycles → MEM_WRITE holds mem_write=1 for 4 cycles. instr_done pulses on the ready cycle, and the next state is FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_err=1 after 4 wait cycles, mem_req drops to 0, and the FSM stays in TRAP until rst_n=0.
- Opcode 63, then opcode 2 with the macro undefined → illegal_op=1 both times, with no reg_write or pc_write. With the macro defined, opcode 2 gives pc_write=1 and pc_source=10 in cycle 3.
- rst_n=0 during MEM_READ → next cycle is in FETCH, with flags cleared and reg_write never asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// Optional jump support is enabled by defining MULTICYCLE_CTRL_JUMP_EN.
package ctrl_pkg;

    localparam logic [5:0] R_FORMAT = 6'd0;
    localparam logic [5:0] J        = 6'd2;
    localparam logic [5:0] BEQ      = 6'd4;
    localparam logic [5:0] BNE      = 6'd5;
    localparam logic [5:0] ADDI     = 6'd8;
    localparam logic [5:0] ANDI     = 6'd12;
    localparam logic [5:0] ORI      = 6'd13;
    localparam logic [5:0] LW       = 6'd35;
    localparam logic [5:0] SW       = 6'd43;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
`ifdef MULTICYCLE_CTRL_JUMP_EN
        S_JUMP,
`endif
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_MEM,
        CLS_BR,
        CLS_IMM,
        CLS_JMP,
        CLS_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier with per-opcode ALU operation.
// Opcode J is only legal when MULTICYCLE_CTRL_JUMP_EN is defined.
module opcode_class
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output op_class_e           op_class_o,
    output logic [2:0]          alu_op_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        alu_op_o   = ALU_ADD;
        unique case (1'b1)
            (opcode_i == OPCODE_W'(R_FORMAT)): begin
                op_class_o = CLS_R;
                alu_op_o   = ALU_FUNC;
            end
            (opcode_i == OPCODE_W'(LW)),
            (opcode_i == OPCODE_W'(SW)): begin
                op_class_o = CLS_MEM;
            end
            (opcode_i == OPCODE_W'(BEQ)),
            (opcode_i == OPCODE_W'(BNE)): begin
                op_class_o = CLS_BR;
                alu_op_o   = ALU_SUB;
            end
            (opcode_i == OPCODE_W'(ADDI)): begin
                op_class_o = CLS_IMM;
            end
            (opcode_i == OPCODE_W'(ANDI)): begin
                op_class_o = CLS_IMM;
                alu_op_o   = ALU_AND;
            end
            (opcode_i == OPCODE_W'(ORI)): begin
                op_class_o = CLS_IMM;
                alu_op_o   = ALU_OR;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            (opcode_i == OPCODE_W'(J)): begin
                op_class_o = CLS_JMP;
            end
`endif
            default: begin
                op_class_o = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory handshake and traps.
// Define MULTICYCLE_CTRL_JUMP_EN to add the one-cycle JUMP state.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                pc_write_ne,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                bus_err
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 2);
    localparam int WLAST  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WLAST);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_q, wait_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;

    logic [OPCODE_W-1:0] op_sel;
    op_class_e           op_cls;
    logic [2:0]          cls_alu_op;
    logic [2:0]          alu_op3;
    logic                timeout;

    // DECODE classifies the live opcode; later states use the latched copy.
    assign op_sel = (state_q == S_DECODE) ? opcode : opcode_q;

    opcode_class #(
        .OPCODE_W (OPCODE_W)
    ) u_opcode_class (
        .opcode_i   (op_sel),
        .op_class_o (op_cls),
        .alu_op_o   (cls_alu_op)
    );

    assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    assign alu_op     = ALUOP_W'(alu_op3);
    assign illegal_op = illegal_q;
    assign bus_err    = bus_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        opcode_d      = opcode_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_write_ne   = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op3       = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                opcode_d  = opcode;
                unique case (op_cls)
                    CLS_R:   state_d = S_EXEC_R;
                    CLS_MEM: state_d = S_MEM_ADDR;
                    CLS_BR:  state_d = S_BRANCH;
                    CLS_IMM: state_d = S_EXEC_I;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    CLS_JMP: state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op3   = ALU_FUNC;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op3   = cls_alu_op;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode_q == OPCODE_W'(LW)) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_MEM_READ: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op3    = ALU_SUB;
                pc_source  = PCSRC_ALUOUT;
                instr_done = 1'b1;
                if (opcode_q == OPCODE_W'(BEQ)) begin
                    pc_write_cond = 1'b1;
                end else begin
                    pc_write_ne = 1'b1;
                end
                state_d = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Any state change restarts the wait count for the next access.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_req && !mem_ready && (wait_q != '1)) begin
            wait_d = wait_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Handles both builds of MULTICYCLE_CTRL_JUMP_EN.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_cond;
        logic       pc_ne;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       done;
        logic       ill;
        logic       berr;
    } ctl_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_read, mem_write, iord;
    logic       ir_write, pc_write, pc_write_cond, pc_write_ne;
    logic       reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done, illegal_op, bus_err;

    int checks   = 0;
    int failures = 0;
    ctl_t cur;

    multicycle_control #(
        .OPCODE_W    (6),
        .ALUOP_W     (3),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_write_ne   (pc_write_ne),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .bus_err       (bus_err)
    );

    assign cur = {mem_req, mem_read, mem_write, iord,
                  ir_write, pc_write, pc_write_cond, pc_write_ne,
                  reg_dst, reg_write, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, pc_source,
                  instr_done, illegal_op, bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.src_b    = 2'b01;
        c.ir_write = rdy;
        c.pc_write = rdy;
        return c;
    endfunction

    function automatic ctl_t e_dec();
        ctl_t c = '0;
        c.src_b = 2'b11;
        return c;
    endfunction

    function automatic ctl_t e_exec_r();
        ctl_t c = '0;
        c.src_a  = 1'b1;
        c.alu_op = 3'b010;
        return c;
    endfunction

    function automatic ctl_t e_rwb();
        ctl_t c = '0;
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_exec_i(input logic [2:0] op);
        ctl_t c = '0;
        c.src_a  = 1'b1;
        c.src_b  = 2'b10;
        c.alu_op = op;
        return c;
    endfunction

    function automatic ctl_t e_iwb();
        ctl_t c = '0;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_mread();
        ctl_t c = '0;
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_mwb();
        ctl_t c = '0;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_mwrite(input logic rdy);
        ctl_t c = '0;
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.done      = rdy;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic ne);
        ctl_t c = '0;
        c.src_a   = 1'b1;
        c.alu_op  = 3'b001;
        c.pc_src  = 2'b01;
        c.pc_cond = ~ne;
        c.pc_ne   = ne;
        c.done    = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_trap(input logic ill, input logic berr);
        ctl_t c = '0;
        c.ill  = ill;
        c.berr = berr;
        return c;
    endfunction

    task automatic step(input logic rdy, input logic [5:0] opc,
                        input string tag, input ctl_t exp);
        mem_ready = rdy;
        opcode    = opc;
        #1;
        checks++;
        assert (cur === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, cur, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        do_reset();

        // Reset state: FETCH decode, ready low
        step(1'b0, 6'd0,  "reset_fetch", e_fetch(1'b0));

        // ADD then LW with ready tied high
        step(1'b1, 6'd0,  "add_c1_fetch", e_fetch(1'b1));
        step(1'b1, 6'd0,  "add_c2_dec",   e_dec());
        step(1'b1, 6'd0,  "add_c3_exec",  e_exec_r());
        step(1'b1, 6'd0,  "add_c4_wb",    e_rwb());
        step(1'b1, 6'd35, "lw_c5_fetch",  e_fetch(1'b1));
        step(1'b1, 6'd35, "lw_c6_dec",    e_dec());
        step(1'b1, 6'd0,  "lw_c7_addr",   e_exec_i(3'b000));
        step(1'b1, 6'd0,  "lw_c8_read",   e_mread());
        step(1'b1, 6'd0,  "lw_c9_wb",     e_mwb());

        // ORI / ANDI / ADDI, opcode changed after DECODE
        step(1'b1, 6'd13, "ori_fetch", e_fetch(1'b1));
        step(1'b1, 6'd13, "ori_dec",   e_dec());
        step(1'b1, 6'd12, "ori_exec",  e_exec_i(3'b100));
        step(1'b1, 6'd12, "ori_wb",    e_iwb());
        step(1'b1, 6'd12, "andi_fetch", e_fetch(1'b1));
        step(1'b1, 6'd12, "andi_dec",   e_dec());
        step(1'b1, 6'd13, "andi_exec",  e_exec_i(3'b011));
        step(1'b1, 6'd13, "andi_wb",    e_iwb());
        step(1'b1, 6'd8,  "addi_fetch", e_fetch(1'b1));
        step(1'b1, 6'd8,  "addi_dec",   e_dec());
        step(1'b1, 6'd13, "addi_exec",  e_exec_i(3'b000));
        step(1'b1, 6'd13, "addi_wb",    e_iwb());

        // SW with 3 wait cycles
        step(1'b1, 6'd43, "sw_fetch", e_fetch(1'b1));
        step(1'b1, 6'd43, "sw_dec",   e_dec());
        step(1'b1, 6'd35, "sw_addr",  e_exec_i(3'b000));
        step(1'b0, 6'd35, "sw_wait1", e_mwrite(1'b0));
        step(1'b0, 6'd35, "sw_wait2", e_mwrite(1'b0));
        step(1'b0, 6'd35, "sw_wait3", e_mwrite(1'b0));
        step(1'b1, 6'd35, "sw_ready", e_mwrite(1'b1));
        step(1'b1, 6'd4,  "sw_next_fetch", e_fetch(1'b1));

        // BEQ then BNE
        step(1'b1, 6'd4, "beq_dec",    e_dec());
        step(1'b1, 6'd0, "beq_branch", e_branch(1'b0));
        step(1'b1, 6'd5, "bne_fetch",  e_fetch(1'b1));
        step(1'b1, 6'd5, "bne_dec",    e_dec());
        step(1'b1, 6'd0, "bne_branch", e_branch(1'b1));

        // Illegal opcode 63
        step(1'b1, 6'd63, "ill63_fetch", e_fetch(1'b1));
        step(1'b1, 6'd63, "ill63_dec",   e_dec());
        step(1'b1, 6'd0,  "ill63_trap",  e_trap(1'b1, 1'b0));
        step(1'b1, 6'd0,  "ill63_hold",  e_trap(1'b1, 1'b0));
        do_reset();
        step(1'b1, 6'd2, "rst_clears_ill", e_fetch(1'b1));

        // Opcode 2: jump or trap depending on build
        step(1'b1, 6'd2, "j_dec", e_dec());
`ifdef MULTICYCLE_CTRL_JUMP_EN
        begin
            ctl_t ej;
            ej        = '0;
            ej.pc_write = 1'b1;
            ej.pc_src = 2'b10;
            ej.done   = 1'b1;
            step(1'b1, 6'd0, "j_jump",  ej);
            step(1'b1, 6'd0, "j_fetch", e_fetch(1'b1));
        end
`else
        step(1'b1, 6'd0, "j_trap", e_trap(1'b1, 1'b0));
        step(1'b1, 6'd0, "j_hold", e_trap(1'b1, 1'b0));
`endif
        do_reset();

        // Timeout in FETCH after 4 wait cycles
        step(1'b0, 6'd0, "to_w1", e_fetch(1'b0));
        step(1'b0, 6'd0, "to_w2", e_fetch(1'b0));
        step(1'b0, 6'd0, "to_w3", e_fetch(1'b0));
        step(1'b0, 6'd0, "to_w4", e_fetch(1'b0));
        step(1'b0, 6'd0, "to_trap",  e_trap(1'b0, 1'b1));
        step(1'b1, 6'd0, "to_hold1", e_trap(1'b0, 1'b1));
        step(1'b1, 6'd0, "to_hold2", e_trap(1'b0, 1'b1));
        do_reset();

        // Reset during MEM_READ
        step(1'b1, 6'd35, "rr_fetch", e_fetch(1'b1));
        step(1'b1, 6'd35, "rr_dec",   e_dec());
        step(1'b1, 6'd35, "rr_addr",  e_exec_i(3'b000));
        step(1'b0, 6'd35, "rr_read",  e_mread());
        do_reset();
        step(1'b0, 6'd0, "rr_after_reset", e_fetch(1'b0));
        step(1'b1, 6'd0, "rr_refetch",     e_fetch(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
